// File: rtl/wall_map_server.sv
// Game-field wall bitmap with a registered VGA read port, a registered game query port
// and a small write queue whose entries are committed only while the VGA side is idle.
`timescale 1ns/1ps
module wall_map_server #(
  parameter int MAP_W    = 64,
  parameter int MAP_H    = 44,
  parameter int WQ_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_init,
  input  logic       i_vga_buzy,
  input  logic [5:0] i_req_x,
  input  logic [5:0] i_req_y,
  output logic       o_is_wall,
  input  logic [5:0] i_q_x,
  input  logic [5:0] i_q_y,
  output logic       o_q_wall,
  input  logic       i_wr_valid,
  output logic       o_wr_ready,
  input  logic [5:0] i_wr_x,
  input  logic [5:0] i_wr_y,
  input  logic       i_wr_data,
  output logic       o_pending,
  output logic       o_ready,
  output logic [0:0] o_dbg_state
);

  localparam int MAP_N = MAP_W * MAP_H;
  localparam int PW    = $clog2(WQ_DEPTH);

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_IDLE  = 1'b1;

  localparam logic [PW-1:0] PTR_ONE = 1;
  localparam logic [PW:0]   CNT_ONE = 1;
  localparam logic [PW:0]   CNT_MAX = (PW+1)'(WQ_DEPTH);

  // Handshake: a write transfers on a rising clk edge where i_wr_valid & o_wr_ready are both 1.
  logic [0:0]       state;
  logic [5:0]       clr_x, clr_y;
  logic [11:0]      clr_idx;
  logic             clr_bit, clr_last;
  logic [MAP_N-1:0] map_bits;

  logic [5:0]       wq_x [WQ_DEPTH];
  logic [5:0]       wq_y [WQ_DEPTH];
  logic             wq_d [WQ_DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [PW:0]      count, count_nxt;
  logic             push, pop;

  function automatic logic in_range(input logic [5:0] x, input logic [5:0] y);
    return ({1'b0, x} < 7'(MAP_W)) && ({1'b0, y} < 7'(MAP_H));
  endfunction

  function automatic logic [11:0] cell_idx(input logic [5:0] x, input logic [5:0] y);
    return 12'(y) * 12'(MAP_W) + 12'(x);
  endfunction

  assign clr_idx  = cell_idx(clr_x, clr_y);
  assign clr_bit  = (clr_x == 6'd0) || (clr_x == 6'(MAP_W - 1)) ||
                    (clr_y == 6'd0) || (clr_y == 6'(MAP_H - 1));
  assign clr_last = (clr_x == 6'(MAP_W - 1)) && (clr_y == 6'(MAP_H - 1));

  // A full queue refuses a push even when a pop would free a slot in the same cycle.
  assign o_wr_ready  = (state == ST_IDLE) && (count != CNT_MAX);
  assign push        = i_wr_valid && o_wr_ready && !i_init;
  assign pop         = (state == ST_IDLE) && !i_vga_buzy && (count != '0) && !i_init;
  assign o_dbg_state = state;

  always_comb begin
    count_nxt = count;
    if (push && !pop)      count_nxt = count + CNT_ONE;
    else if (pop && !push) count_nxt = count - CNT_ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_CLEAR;
      clr_x     <= '0;
      clr_y     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      o_pending <= 1'b0;
      o_ready   <= 1'b0;
    end else if (i_init) begin
      state     <= ST_CLEAR;
      clr_x     <= '0;
      clr_y     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      o_pending <= 1'b0;
      o_ready   <= 1'b0;
    end else begin
      if (state == ST_CLEAR) begin
        if (clr_last) begin
          state   <= ST_IDLE;
          o_ready <= 1'b1;
          clr_x   <= '0;
          clr_y   <= '0;
        end else if (clr_x == 6'(MAP_W - 1)) begin
          clr_x <= '0;
          clr_y <= clr_y + 6'd1;
        end else begin
          clr_x <= clr_x + 6'd1;
        end
      end
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      count     <= count_nxt;
      o_pending <= (count_nxt != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      wq_x[wr_ptr] <= i_wr_x;
      wq_y[wr_ptr] <= i_wr_y;
      wq_d[wr_ptr] <= i_wr_data;
    end
  end

  // Out-of-range queue entries are consumed without touching the map.
  always_ff @(posedge clk) begin
    if (state == ST_CLEAR)
      map_bits[clr_idx] <= clr_bit;
    else if (pop && in_range(wq_x[rd_ptr], wq_y[rd_ptr]))
      map_bits[cell_idx(wq_x[rd_ptr], wq_y[rd_ptr])] <= wq_d[rd_ptr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_is_wall <= 1'b0;
      o_q_wall  <= 1'b0;
    end else begin
      o_is_wall <= (state == ST_CLEAR) || !in_range(i_req_x, i_req_y) ||
                   map_bits[cell_idx(i_req_x, i_req_y)];
      o_q_wall  <= (state == ST_CLEAR) || !in_range(i_q_x, i_q_y) ||
                   map_bits[cell_idx(i_q_x, i_q_y)];
    end
  end

endmodule

// File: tb/tb_wall_map_server.sv
// Self-checking bench for wall_map_server: reference wall map, read scoreboards, one task per scenario.
`timescale 1ns/1ps
module tb_wall_map_server;
  localparam int MAP_W = 64;
  localparam int MAP_H = 44;
  localparam int CLEAR_CYCLES = 2816;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_init = 1'b0;
  logic       i_vga_buzy = 1'b0;
  logic [5:0] i_req_x = '0, i_req_y = '0;
  logic [5:0] i_q_x = '0, i_q_y = '0;
  logic       i_wr_valid = 1'b0;
  logic [5:0] i_wr_x = '0, i_wr_y = '0;
  logic       i_wr_data = 1'b0;
  logic       o_is_wall, o_q_wall, o_wr_ready, o_pending, o_ready;
  logic [0:0] o_dbg_state;

  int checks = 0;
  int errors = 0;

  logic       ref_map [MAP_W][MAP_H];
  logic [0:0] exp_q[$];
  logic [0:0] exp_qq[$];

  wall_map_server dut (
    .clk(clk), .rst_n(rst_n), .i_init(i_init), .i_vga_buzy(i_vga_buzy),
    .i_req_x(i_req_x), .i_req_y(i_req_y), .o_is_wall(o_is_wall),
    .i_q_x(i_q_x), .i_q_y(i_q_y), .o_q_wall(o_q_wall),
    .i_wr_valid(i_wr_valid), .o_wr_ready(o_wr_ready),
    .i_wr_x(i_wr_x), .i_wr_y(i_wr_y), .i_wr_data(i_wr_data),
    .o_pending(o_pending), .o_ready(o_ready), .o_dbg_state(o_dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- model and driver tasks ----------------
  task automatic model_default();
    for (int x = 0; x < MAP_W; x++)
      for (int y = 0; y < MAP_H; y++)
        ref_map[x][y] = (x == 0) || (x == MAP_W - 1) || (y == 0) || (y == MAP_H - 1);
  endtask

  function automatic logic model_read(input int x, input int y);
    if (x >= MAP_W || y >= MAP_H) return 1'b1;
    return ref_map[x][y];
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive_vga(input int x, input int y);
    i_req_x = 6'(x);
    i_req_y = 6'(y);
    exp_q.push_back(model_read(x, y));
  endtask

  task automatic drive_query(input int x, input int y);
    i_q_x = 6'(x);
    i_q_y = 6'(y);
    exp_qq.push_back(model_read(x, y));
  endtask

  task automatic drive_wr(input int x, input int y, input logic d);
    i_wr_valid = 1'b1;
    i_wr_x     = 6'(x);
    i_wr_y     = 6'(y);
    i_wr_data  = d;
  endtask

  task automatic wait_ready(input int start, output int n);
    n = start;
    while (o_ready !== 1'b1 && n < 4000) begin
      tick();
      n++;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    int n;
    rst_n = 1'b0;
    drive_vga(10, 10);
    void'(exp_q.pop_back());
    repeat (3) tick();
    checks++; if (o_is_wall !== 1'b0)  begin errors++; $display("FAIL reset_is_wall got=%b exp=0", o_is_wall); end
    checks++; if (o_q_wall !== 1'b0)   begin errors++; $display("FAIL reset_q_wall got=%b exp=0", o_q_wall); end
    checks++; if (o_wr_ready !== 1'b0) begin errors++; $display("FAIL reset_wr_ready got=%b exp=0", o_wr_ready); end
    checks++; if (o_pending !== 1'b0)  begin errors++; $display("FAIL reset_pending got=%b exp=0", o_pending); end
    checks++; if (o_ready !== 1'b0)    begin errors++; $display("FAIL reset_ready got=%b exp=0", o_ready); end
    rst_n = 1'b1;
    tick();
    checks++; if (o_is_wall !== 1'b1)  begin errors++; $display("FAIL clear_read got=%b exp=1", o_is_wall); end
    checks++; if (o_wr_ready !== 1'b0) begin errors++; $display("FAIL clear_wr_ready got=%b exp=0", o_wr_ready); end
    wait_ready(1, n);
    checks++; if (n != CLEAR_CYCLES) begin errors++; $display("FAIL clear_length got=%0d exp=%0d", n, CLEAR_CYCLES); end
    checks++; if (o_dbg_state !== 1'b1) begin errors++; $display("FAIL state_idle got=%b exp=1", o_dbg_state); end
    model_default();
  endtask

  task automatic test_default_reads();
    int xs[8] = '{0, 10, 63, 0, 5, 32, 62, 5};
    int ys[8] = '{5, 10, 43, 0, 44, 1, 42, 63};
    logic [0:0] e;
    for (int i = 0; i < 8; i++) begin
      drive_vga(xs[i], ys[i]);
      drive_query(xs[7 - i], ys[7 - i]);
      tick();
      e = exp_q.pop_front();
      checks++; if (o_is_wall !== e) begin errors++; $display("FAIL default_vga (%0d,%0d) got=%b exp=%b", xs[i], ys[i], o_is_wall, e); end
      e = exp_qq.pop_front();
      checks++; if (o_q_wall !== e) begin errors++; $display("FAIL default_query (%0d,%0d) got=%b exp=%b", xs[7-i], ys[7-i], o_q_wall, e); end
    end
    for (int i = 0; i < 16; i++) begin
      drive_vga($urandom_range(0, 63), $urandom_range(0, 63));
      drive_query($urandom_range(0, 63), $urandom_range(0, 63));
      tick();
      e = exp_q.pop_front();
      checks++; if (o_is_wall !== e) begin errors++; $display("FAIL rand_vga got=%b exp=%b", o_is_wall, e); end
      e = exp_qq.pop_front();
      checks++; if (o_q_wall !== e) begin errors++; $display("FAIL rand_query got=%b exp=%b", o_q_wall, e); end
    end
  endtask

  task automatic test_single_write();
    logic [0:0] e;
    checks++; if (o_wr_ready !== 1'b1) begin errors++; $display("FAIL single_wr_ready got=%b exp=1", o_wr_ready); end
    drive_wr(10, 10, 1'b1);
    tick();
    i_wr_valid = 1'b0;
    checks++; if (o_pending !== 1'b1) begin errors++; $display("FAIL single_pending_on got=%b exp=1", o_pending); end
    drive_vga(10, 10);  // sampled on the commit edge: old value
    tick();
    e = exp_q.pop_front();
    checks++; if (o_is_wall !== e)    begin errors++; $display("FAIL single_rbw got=%b exp=%b", o_is_wall, e); end
    checks++; if (o_pending !== 1'b0) begin errors++; $display("FAIL single_pending_off got=%b exp=0", o_pending); end
    ref_map[10][10] = 1'b1;
    drive_vga(10, 10);
    tick();
    e = exp_q.pop_front();
    checks++; if (o_is_wall !== e) begin errors++; $display("FAIL single_after got=%b exp=%b", o_is_wall, e); end
  endtask

  task automatic test_buzy_queue();
    int ex[4] = '{20, 21, 22, 20};
    int ey[4] = '{20, 21, 22, 20};
    logic ed[4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic q_seq[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic p_seq[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [0:0] e;
    i_vga_buzy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_wr(ex[i], ey[i], ed[i]);
      tick();
    end
    checks++; if (o_wr_ready !== 1'b0) begin errors++; $display("FAIL buzy_full_ready got=%b exp=0", o_wr_ready); end
    checks++; if (o_pending !== 1'b1)  begin errors++; $display("FAIL buzy_pending got=%b exp=1", o_pending); end
    drive_wr(30, 30, 1'b1);  // refused: queue is full
    drive_query(20, 20);
    tick();
    i_wr_valid = 1'b0;
    e = exp_qq.pop_front();
    checks++; if (o_q_wall !== e)      begin errors++; $display("FAIL buzy_unchanged got=%b exp=%b", o_q_wall, e); end
    checks++; if (o_wr_ready !== 1'b0) begin errors++; $display("FAIL buzy_still_full got=%b exp=0", o_wr_ready); end
    i_vga_buzy = 1'b0;
    for (int k = 0; k < 5; k++) exp_qq.push_back(q_seq[k]);
    for (int k = 0; k < 5; k++) begin
      tick();
      e = exp_qq.pop_front();
      checks++; if (o_q_wall !== e)        begin errors++; $display("FAIL drain_read[%0d] got=%b exp=%b", k, o_q_wall, e); end
      checks++; if (o_pending !== p_seq[k]) begin errors++; $display("FAIL drain_pending[%0d] got=%b exp=%b", k, o_pending, p_seq[k]); end
    end
    ref_map[20][20] = 1'b0;
    ref_map[21][21] = 1'b1;
    ref_map[22][22] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) drive_vga(30, 30); else drive_vga(ex[i + 1], ey[i + 1]);
      tick();
      e = exp_q.pop_front();
      checks++; if (o_is_wall !== e) begin errors++; $display("FAIL drain_cell[%0d] got=%b exp=%b", i, o_is_wall, e); end
    end
  endtask

  task automatic test_back_to_back();
    logic [0:0] e;
    drive_wr(5, 5, 1'b1);
    tick();
    drive_wr(5, 5, 1'b0);
    tick();
    i_wr_valid = 1'b0;
    checks++; if (o_pending !== 1'b1) begin errors++; $display("FAIL b2b_pending got=%b exp=1", o_pending); end
    tick();
    checks++; if (o_pending !== 1'b0) begin errors++; $display("FAIL b2b_drained got=%b exp=0", o_pending); end
    ref_map[5][5] = 1'b0;
    drive_query(5, 5);
    tick();
    e = exp_qq.pop_front();
    checks++; if (o_q_wall !== e) begin errors++; $display("FAIL b2b_final got=%b exp=%b", o_q_wall, e); end
    drive_wr(3, 50, 1'b0);  // out-of-range row
    tick();
    i_wr_valid = 1'b0;
    checks++; if (o_pending !== 1'b1) begin errors++; $display("FAIL oor_pending got=%b exp=1", o_pending); end
    tick();
    checks++; if (o_pending !== 1'b0) begin errors++; $display("FAIL oor_popped got=%b exp=0", o_pending); end
    drive_vga(3, 43);
    drive_query(3, 42);
    tick();
    e = exp_q.pop_front();
    checks++; if (o_is_wall !== e) begin errors++; $display("FAIL oor_border got=%b exp=%b", o_is_wall, e); end
    e = exp_qq.pop_front();
    checks++; if (o_q_wall !== e)  begin errors++; $display("FAIL oor_inner got=%b exp=%b", o_q_wall, e); end
  endtask

  task automatic test_init_flush();
    int n;
    logic [0:0] e;
    int cx[5] = '{10, 40, 41, 0, 63};
    int cy[5] = '{10, 10, 10, 20, 7};
    i_vga_buzy = 1'b1;
    drive_wr(40, 10, 1'b1);
    tick();
    drive_wr(41, 10, 1'b1);
    tick();
    i_wr_valid = 1'b0;
    checks++; if (o_pending !== 1'b1) begin errors++; $display("FAIL init_pre_pending got=%b exp=1", o_pending); end
    i_init = 1'b1;
    tick();
    i_init = 1'b0;
    i_vga_buzy = 1'b0;
    checks++; if (o_pending !== 1'b0)  begin errors++; $display("FAIL init_pending got=%b exp=0", o_pending); end
    checks++; if (o_ready !== 1'b0)    begin errors++; $display("FAIL init_ready got=%b exp=0", o_ready); end
    checks++; if (o_wr_ready !== 1'b0) begin errors++; $display("FAIL init_wr_ready got=%b exp=0", o_wr_ready); end
    i_q_x = 6'd30;
    i_q_y = 6'd30;
    tick();
    checks++; if (o_q_wall !== 1'b1) begin errors++; $display("FAIL init_clear_read got=%b exp=1", o_q_wall); end
    repeat (100) tick();
    i_init = 1'b1;  // restart the sweep mid-clear
    tick();
    i_init = 1'b0;
    wait_ready(0, n);
    checks++; if (n != CLEAR_CYCLES) begin errors++; $display("FAIL init_restart_len got=%0d exp=%0d", n, CLEAR_CYCLES); end
    model_default();
    for (int i = 0; i < 5; i++) begin
      drive_vga(cx[i], cy[i]);
      tick();
      e = exp_q.pop_front();
      checks++; if (o_is_wall !== e) begin errors++; $display("FAIL init_map (%0d,%0d) got=%b exp=%b", cx[i], cy[i], o_is_wall, e); end
    end
  endtask

  task automatic test_reset_mid();
    int n;
    i_init = 1'b1;
    tick();
    i_init = 1'b0;
    repeat (1000) tick();
    #2 rst_n = 1'b0;
    #1;
    checks++; if (o_is_wall !== 1'b0) begin errors++; $display("FAIL mid_is_wall got=%b exp=0", o_is_wall); end
    checks++; if (o_q_wall !== 1'b0)  begin errors++; $display("FAIL mid_q_wall got=%b exp=0", o_q_wall); end
    checks++; if (o_ready !== 1'b0 || o_pending !== 1'b0 || o_wr_ready !== 1'b0)
      begin errors++; $display("FAIL mid_ctrl got=%b%b%b exp=000", o_ready, o_pending, o_wr_ready); end
    tick();
    rst_n = 1'b1;
    wait_ready(0, n);
    checks++; if (n != CLEAR_CYCLES) begin errors++; $display("FAIL mid_restart_len got=%0d exp=%0d", n, CLEAR_CYCLES); end
    model_default();
  endtask

  task automatic test_random_writes();
    int x, y;
    logic d;
    logic [0:0] e;
    for (int i = 0; i < 12; i++) begin
      x = $urandom_range(1, 62);
      y = $urandom_range(1, 42);
      d = 1'($urandom_range(0, 1));
      drive_wr(x, y, d);
      tick();
      i_wr_valid = 1'b0;
      tick();
      ref_map[x][y] = d;
      drive_vga(x, y);
      drive_query($urandom_range(0, 63), $urandom_range(0, 63));
      tick();
      e = exp_q.pop_front();
      checks++; if (o_is_wall !== e) begin errors++; $display("FAIL rw_vga (%0d,%0d) got=%b exp=%b", x, y, o_is_wall, e); end
      e = exp_qq.pop_front();
      checks++; if (o_q_wall !== e)  begin errors++; $display("FAIL rw_query got=%b exp=%b", o_q_wall, e); end
    end
  endtask

  initial begin
    test_reset();
    test_default_reads();
    test_single_write();
    test_buzy_queue();
    test_back_to_back();
    test_init_flush();
    test_reset_mid();
    test_random_writes();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
